// File: rtl/cpu_reg_write_arbiter.sv
// Merges memory and ALU writebacks onto the single register-bank write port.
// Deferred writes wait in an in-order FIFO; query_hit flags registers still in flight.
module cpu_reg_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_WIDTH-1:0]         mem_reg,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_WIDTH-1:0]         alu_reg,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    output logic                          bank_write_enable,
    output logic [ADDR_WIDTH-1:0]         bank_write_reg,
    output logic [DATA_WIDTH-1:0]         bank_write_data,
    input  logic [ADDR_WIDTH-1:0]         query_reg,
    output logic                          query_hit,
    output logic [$clog2(FIFO_DEPTH):0]   pending_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_reg_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  bank_we_q;
    logic [ADDR_WIDTH-1:0] bank_reg_q;
    logic [DATA_WIDTH-1:0] bank_data_q;

    logic                  ready;
    logic                  mem_acc, alu_acc, head_valid;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_reg;
    logic [DATA_WIDTH-1:0] issue_data;
    logic                  enq0_valid, enq1_valid;
    logic [ADDR_WIDTH-1:0] enq0_reg, enq1_reg;
    logic [DATA_WIDTH-1:0] enq0_data, enq1_data;

    // Ready depends on state only, so valid can never loop back into it.
    assign ready      = !reset && (count_q < FULL);
    assign mem_ready  = ready;
    assign alu_ready  = ready;
    // Writes to r0 complete the handshake but are dropped here.
    assign mem_acc    = mem_valid && ready && (mem_reg != '0);
    assign alu_acc    = alu_valid && ready && (alu_reg != '0);
    assign head_valid = (count_q != '0);

    // Oldest candidate issues; the rest enqueue in age order (mem before ALU).
    always_comb begin
        issue_valid = 1'b0;
        issue_reg   = '0;
        issue_data  = '0;
        enq0_valid  = 1'b0;
        enq0_reg    = alu_reg;
        enq0_data   = alu_data;
        enq1_valid  = 1'b0;
        enq1_reg    = alu_reg;
        enq1_data   = alu_data;
        if (head_valid) begin
            issue_valid = 1'b1;
            issue_reg   = fifo_reg_q[rd_ptr_q];
            issue_data  = fifo_data_q[rd_ptr_q];
            if (mem_acc) begin
                enq0_valid = 1'b1;
                enq0_reg   = mem_reg;
                enq0_data  = mem_data;
                enq1_valid = alu_acc;
            end else begin
                enq0_valid = alu_acc;
            end
        end else if (mem_acc) begin
            issue_valid = 1'b1;
            issue_reg   = mem_reg;
            issue_data  = mem_data;
            enq0_valid  = alu_acc;
        end else if (alu_acc) begin
            issue_valid = 1'b1;
            issue_reg   = alu_reg;
            issue_data  = alu_data;
        end
    end

    always_comb begin
        count_d  = count_q + CW'(enq0_valid) + CW'(enq1_valid) - CW'(head_valid);
        wr_ptr_d = wr_ptr_q + PW'(enq0_valid) + PW'(enq1_valid);
        rd_ptr_d = rd_ptr_q + PW'(head_valid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            bank_we_q   <= 1'b0;
            bank_reg_q  <= '0;
            bank_data_q <= '0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            bank_we_q <= issue_valid;
            if (issue_valid) begin
                bank_reg_q  <= issue_reg;
                bank_data_q <= issue_data;
            end
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (enq0_valid) begin
                fifo_reg_q[wr_ptr_q]  <= enq0_reg;
                fifo_data_q[wr_ptr_q] <= enq0_data;
            end
            if (enq1_valid) begin
                fifo_reg_q[wr_ptr_q + PW'(1)]  <= enq1_reg;
                fifo_data_q[wr_ptr_q + PW'(1)] <= enq1_data;
            end
        end
    end

    always_comb begin
        query_hit = 1'b0;
        if (query_reg != '0) begin
            if (bank_we_q && (bank_reg_q == query_reg)) begin
                query_hit = 1'b1;
            end
            for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                if ((CW'(k) < count_q) && (fifo_reg_q[rd_ptr_q + PW'(k)] == query_reg)) begin
                    query_hit = 1'b1;
                end
            end
        end
    end

    assign bank_write_enable = bank_we_q;
    assign bank_write_reg    = bank_reg_q;
    assign bank_write_data   = bank_data_q;
    assign pending_count     = count_q;

endmodule

// File: tb/tb_cpu_reg_write_arbiter.sv
// Directed bench for cpu_reg_write_arbiter with a behavioural register bank
// that captures every write seen on the bank port.
module tb_cpu_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_reg = '0;
    logic [31:0] mem_data = '0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        bank_write_enable;
    logic [4:0]  bank_write_reg;
    logic [31:0] bank_write_data;
    logic [4:0]  query_reg = '0;
    logic        query_hit;
    logic [1:0]  pending_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_bank [32] = '{default: '0};

    cpu_reg_write_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .FIFO_DEPTH(2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_reg           (mem_reg),
        .mem_data          (mem_data),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .alu_reg           (alu_reg),
        .alu_data          (alu_data),
        .bank_write_enable (bank_write_enable),
        .bank_write_reg    (bank_write_reg),
        .bank_write_data   (bank_write_data),
        .query_reg         (query_reg),
        .query_hit         (query_hit),
        .pending_count     (pending_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bank_write_enable) tb_bank[bank_write_reg] <= bank_write_data;
    end

    // FIFO can never hold more than its two entries.
    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if (pending_count > 2'd2) begin
                errors++;
                $display("FAIL overflow: pending_count %0d required <= 2", pending_count);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_port(input string name, input logic we, input logic [4:0] r,
                              input logic [31:0] d, input logic [1:0] cnt);
        checks++;
        if (bank_write_enable !== we || (we && (bank_write_reg !== r || bank_write_data !== d))
            || pending_count !== cnt) begin
            errors++;
            $display("FAIL %s: got we=%0b reg=%0d data=%0h cnt=%0d required we=%0b reg=%0d data=%0h cnt=%0d",
                     name, bank_write_enable, bank_write_reg, bank_write_data, pending_count,
                     we, r, d, cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bank_write_enable !== 1'b0 || bank_write_reg !== 5'd0 || bank_write_data !== 32'd0
            || pending_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got we=%0b reg=%0d data=%0h cnt=%0d required all zero",
                     bank_write_enable, bank_write_reg, bank_write_data, pending_count);
        end
        checks++;
        if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %0b/%0b required 0/0", mem_ready, alu_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %0b/%0b required 1/1", mem_ready, alu_ready);
        end
    endtask

    task automatic test_mem_only();
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'd2;
        tick();
        mem_valid = 1'b0;
        check_port("mem_only", 1'b1, 5'd2, 32'd2, 2'd0);
        tick();
        check_port("mem_only_idle", 1'b0, 5'd0, 32'd0, 2'd0);
        checks++;
        if (tb_bank[2] !== 32'd2) begin
            errors++;
            $display("FAIL bank_r2: got %0h required 2", tb_bank[2]);
        end
    endtask

    task automatic test_same_cycle();
        mem_valid = 1'b1; mem_reg = 5'd1; mem_data = 32'h14;
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check_port("pair_first", 1'b1, 5'd1, 32'h14, 2'd1);
        tick();
        check_port("pair_second", 1'b1, 5'd3, 32'h33, 2'd0);
        tick();
        check_port("pair_idle", 1'b0, 5'd0, 32'd0, 2'd0);
    endtask

    task automatic test_back_to_back();
        logic       exp_ready [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_cnt   [9] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0};
        int p = 0;
        logic acc;
        logic saw_full = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (p < 4) begin
                mem_valid = 1'b1; mem_reg = 5'(10 + 2 * p); mem_data = 32'h1000 + 32'(10 + 2 * p);
                alu_valid = 1'b1; alu_reg = 5'(11 + 2 * p); alu_data = 32'h1000 + 32'(11 + 2 * p);
            end else begin
                mem_valid = 1'b0; alu_valid = 1'b0;
            end
            #1;
            if (c < 8) begin
                checks++;
                if (mem_ready !== exp_ready[c] || alu_ready !== exp_ready[c]) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %0b/%0b required %0b", c, mem_ready,
                             alu_ready, exp_ready[c]);
                end
            end
            acc = mem_ready && mem_valid;
            tick();
            if (acc) p++;
            if (pending_count == 2'd2) saw_full = 1'b1;
            if (c < 8) check_port("b2b_issue", 1'b1, 5'(10 + c), 32'h1000 + 32'(10 + c), exp_cnt[c]);
            else check_port("b2b_idle", 1'b0, 5'd0, 32'd0, exp_cnt[c]);
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        checks++;
        if (p !== 4 || saw_full !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accepts: got pairs=%0d full=%0b required 4/1", p, saw_full);
        end
    endtask

    task automatic test_same_reg();
        query_reg = 5'd5;
        mem_valid = 1'b1; mem_reg = 5'd5; mem_data = 32'hAA;
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hBB;
        #1;
        checks++;
        if (query_hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_before_accept: got %0b required 0", query_hit);
        end
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check_port("same_reg_aa", 1'b1, 5'd5, 32'hAA, 2'd1);
        checks++;
        if (query_hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_aa: got %0b required 1", query_hit);
        end
        tick();
        check_port("same_reg_bb", 1'b1, 5'd5, 32'hBB, 2'd0);
        checks++;
        if (query_hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_bb: got %0b required 1", query_hit);
        end
        tick();
        checks++;
        if (query_hit !== 1'b0 || tb_bank[5] !== 32'hBB) begin
            errors++;
            $display("FAIL same_reg_final: got hit=%0b r5=%0h required 0/bb", query_hit, tb_bank[5]);
        end
    endtask

    task automatic test_r0();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFF;
        query_reg = 5'd0;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_ready: got %0b required 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        check_port("r0_dropped", 1'b0, 5'd0, 32'd0, 2'd0);
        checks++;
        if (query_hit !== 1'b0) begin
            errors++;
            $display("FAIL r0_hit: got %0b required 0", query_hit);
        end
        tick();
        check_port("r0_still_idle", 1'b0, 5'd0, 32'd0, 2'd0);
    endtask

    task automatic test_reset_mid();
        mem_valid = 1'b1; mem_reg = 5'd20; mem_data = 32'h1014;
        alu_valid = 1'b1; alu_reg = 5'd21; alu_data = 32'h1015;
        tick();
        mem_reg = 5'd22; mem_data = 32'h1016;
        alu_reg = 5'd23; alu_data = 32'h1017;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        query_reg = 5'd23;
        check_port("fill_two", 1'b1, 5'd21, 32'h1015, 2'd2);
        #1;
        checks++;
        if (mem_ready !== 1'b0 || query_hit !== 1'b1) begin
            errors++;
            $display("FAIL full_state: got ready=%0b hit=%0b required 0/1", mem_ready, query_hit);
        end
        reset = 1'b1;
        tick();
        check_port("mid_reset", 1'b0, 5'd0, 32'd0, 2'd0);
        checks++;
        if (mem_ready !== 1'b0 || query_hit !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: got ready=%0b hit=%0b required 0/0", mem_ready, query_hit);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_return: got %0b/%0b required 1/1", mem_ready, alu_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check_port("post_reset_idle", 1'b0, 5'd0, 32'd0, 2'd0);
        end
        checks++;
        if (tb_bank[21] !== 32'h1015 || tb_bank[22] !== 32'd0 || tb_bank[23] !== 32'd0) begin
            errors++;
            $display("FAIL dropped_writes: got r21=%0h r22=%0h r23=%0h required 1015/0/0",
                     tb_bank[21], tb_bank[22], tb_bank[23]);
        end
    endtask

    initial begin
        test_reset();
        test_mem_only();
        test_same_cycle();
        test_back_to_back();
        test_same_reg();
        test_r0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_reg_write_arbiter.md
Name: cpu_reg_write_arbiter

Overview:
- Shares the single write port of the CPU register bank between two writeback requesters: memory (load) and ALU.
- Issues at most one register write per cycle through a registered write port.
- Holds deferred writes in a small in-order FIFO.
- Exposes a pending-write hazard query so decode can stall on registers whose write has not yet reached the bank.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register index width (32 registers)
FIFO_DEPTH, 2, deferred-write FIFO entries (power of two, >=2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
mem_valid  input  1  memory writeback request
mem_ready  output  1  arbiter can accept memory request
mem_reg  input  ADDR_WIDTH  memory destination register
mem_data  input  DATA_WIDTH  memory write data
alu_valid  input  1  ALU writeback request
alu_ready  output  1  arbiter can accept ALU request
alu_reg  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU write data
bank_write_enable  output  1  to register bank write_enable
bank_write_reg  output  ADDR_WIDTH  to register bank write_reg
bank_write_data  output  DATA_WIDTH  to register bank write_data
query_reg  input  ADDR_WIDTH  register index checked for a pending write
query_hit  output  1  a write to query_reg is queued or on the bank port
pending_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, synchronous:
  - FIFO empty; pending_count=0.
  - bank_write_enable=0, bank_write_reg=0, bank_write_data=0.
  - mem_ready=alu_ready=0 while reset is high.
- Handshake:
  - A request is accepted on a rising edge where valid&&ready.
  - mem_ready = alu_ready = !reset && (pending_count < FIFO_DEPTH).
  - Ready depends only on state, never on valid, so there is no combinational loop.
  - Requesters hold reg/data stable until accepted.
- Register 0: an accepted request with reg==0 completes the handshake, is discarded, never enqueued or issued, and never causes query_hit.
- Age order each cycle: FIFO head (oldest) > accepted mem > accepted ALU. Within one cycle mem is older than ALU.
- Issue: the oldest live candidate drives the bank port registers on the edge.
  - Remaining accepted candidates are enqueued in age order: mem before ALU.
  - If no candidate: bank_write_enable<=0; reg/data hold their last values.
- Latency: a request accepted into an empty FIFO with no older competitor appears on the bank port one cycle after the accept edge. Each queued entry adds one cycle.
- Capacity: worst case per cycle is +2 enqueued and -1 issued. Ready requiring one free slot guarantees no overflow. Enqueue while full cannot occur; the bench asserts this.
- Same-register writes are issued strictly in age order, so the last-accepted (ALU, within a cycle) value is final in the bank.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Simultaneous enqueue and dequeue at full: allowed only when the net change is <=0. Because of the ready rule this case reduces to dequeue-only.
- query_hit is combinational. It is 1 iff query_reg!=0 and query_reg matches a valid FIFO entry, or matches bank_write_reg while bank_write_enable=1. Requests not yet accepted do not count.
- Reset mid-operation: all queued writes are dropped and nothing further is issued. The bank port deasserts on the reset edge.

Test Plan:
- Reset for 1 cycle, then mem only: mem_reg=2, mem_data=2 -> next cycle bank_write_enable=1, reg=2, data=2; pending_count=0; bank read of r2 afterwards returns 2.
- Same-cycle mem(r1,0x14) and ALU(r3,0x33) -> cycle+1 bank writes r1=0x14, cycle+2 r3=0x33; pending_count=1 during cycle+1, then 0.
- Both requesters fire every cycle for 4 cycles with distinct regs -> FIFO fills to 2, ready drops to 0, no lost or reordered writes; issue order is mem0, alu0, mem1, alu1, ... continuing in age order.
- Same register, same cycle: mem(r5,0xAA), ALU(r5,0xBB) -> writes 0xAA then 0xBB; final r5=0xBB; query_reg=5 gives query_hit=1 until the 0xBB write leaves the port, then 0.
- Write to r0: alu(r0,0xFF) -> accepted, bank_write_enable stays 0, query_reg=0 gives query_hit=0.
- Fill the FIFO to 2, then assert reset for 1 cycle -> pending_count=0, bank_write_enable=0, queued writes never appear; ready returns to 1 on the first cycle after reset.
